// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, format codes and the decoded bundle shared by the decode stage.
package decode_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    fmt_e        fmt;
    logic        illegal;
  } dec_bundle_t;
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational field split, format classification and sign-extended immediate.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output dec_bundle_t     o_dec,
  output logic [XLEN-1:0] o_imm
);
  logic [6:0]  w_op;
  logic        w_std;
  fmt_e        w_fmt;
  logic [31:0] w_imm32;
  assign w_op  = i_instr[6:0];
  assign w_std = i_instr[1:0] == 2'b11;
  assign w_fmt = !w_std ? FMT_NONE :
                 w_op == OP_R ? FMT_R :
                 (w_op == OP_IMM || w_op == OP_LOAD || w_op == OP_JALR || w_op == OP_SYSTEM) ? FMT_I :
                 w_op == OP_STORE ? FMT_S :
                 w_op == OP_BRANCH ? FMT_B :
                 (w_op == OP_LUI || w_op == OP_AUIPC) ? FMT_U :
                 w_op == OP_JAL ? FMT_J : FMT_NONE;
  assign w_imm32 = w_fmt == FMT_I ? {{20{i_instr[31]}}, i_instr[31:20]} :
                   w_fmt == FMT_S ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
                   w_fmt == FMT_B ? {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                   w_fmt == FMT_U ? {i_instr[31:12], 12'b0} :
                   w_fmt == FMT_J ? {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                   32'b0;
  assign o_imm = XLEN'($signed(w_imm32));
  assign o_dec = '{
    instr:   i_instr,
    opcode:  i_instr[6:0],
    rd:      i_instr[11:7],
    funct3:  i_instr[14:12],
    rs1:     i_instr[19:15],
    rs2:     i_instr[24:20],
    funct7:  i_instr[31:25],
    fmt:     w_fmt,
    illegal: w_fmt == FMT_NONE
  };
endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-cycle instruction decode with an output register plus a skid entry.
// in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] dec_count
);
  dec_bundle_t      w_dec, r_out, r_skid;
  logic [XLEN-1:0]  w_imm, r_out_imm, r_skid_imm, r_out_pc, r_skid_pc;
  logic             r_out_valid, r_skid_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_in_fire, w_out_fire, w_load_out;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (in_instr),
    .o_dec   (w_dec),
    .o_imm   (w_imm)
  );
  assign w_in_fire  = in_valid && !r_skid_valid;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_load_out = !r_out_valid || w_out_fire;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_imm    <= '0;
      r_skid_imm   <= '0;
      r_out_pc     <= '0;
      r_skid_pc    <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_out_fire) r_count <= r_count + CNT_W'(1);
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_load_out) begin
        // a full skid entry always has priority so acceptance order is kept
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_imm    <= r_skid_imm;
          r_out_pc     <= r_skid_pc;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_in_fire;
          if (w_in_fire) begin
            r_out     <= w_dec;
            r_out_imm <= w_imm;
            r_out_pc  <= in_pc;
          end
        end
      end else if (w_in_fire) begin
        r_skid       <= w_dec;
        r_skid_imm   <= w_imm;
        r_skid_pc    <= in_pc;
        r_skid_valid <= 1'b1;
      end
    end
  end
  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_opcode  = r_out.opcode;
  assign out_rd      = r_out.rd;
  assign out_funct3  = r_out.funct3;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_funct7  = r_out.funct7;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out.instr;
  assign dec_count   = r_count;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, skid buffering, flush, reset and counter wrap.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_instr, out_instr;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [6:0]       out_opcode, out_funct7;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_funct3, out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] dec_count;
  int               n_tests = 0;
  int               n_fail  = 0;
  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_pc(out_pc), .out_instr(out_instr),
    .dec_count(dec_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", dec_count, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_instr", out_instr, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h1000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", out_valid, 1);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_illegal", out_illegal, 0);
    chk("addi_pc", out_pc, 32'h1000);
    tick();
    chk("addi_count", dec_count, 1);
    chk("addi_drained", out_valid, 0);
    drive(1'b1, 32'h0020A423, 32'h1004);
    tick();
    chk("sw_fmt", out_fmt, 2);
    chk("sw_imm", out_imm, 8);
    chk("sw_rs1", out_rs1, 1);
    chk("sw_rs2", out_rs2, 2);
    chk("sw_funct3", out_funct3, 2);
    drive(1'b1, 32'hFE000EE3, 32'h1008);
    tick();
    chk("beq_fmt", out_fmt, 3);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_funct7", out_funct7, 7'h7F);
    drive(1'b1, 32'h123452B7, 32'h100C);
    tick();
    chk("lui_fmt", out_fmt, 4);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rd", out_rd, 5);
    drive(1'b1, 32'h0080006F, 32'h1010);
    tick();
    chk("jal_fmt", out_fmt, 5);
    chk("jal_imm", out_imm, 8);
    drive(1'b1, 32'h002081B3, 32'h1014);
    tick();
    chk("add_fmt", out_fmt, 0);
    chk("add_imm", out_imm, 0);
    chk("add_rd", out_rd, 3);
    chk("add_opcode", out_opcode, 7'h33);
    drive(1'b1, 32'h00000000, 32'h1018);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("zero_illegal", out_illegal, 1);
    chk("zero_fmt", out_fmt, 6);
    chk("zero_imm", out_imm, 0);
    tick();
    chk("stream_count", dec_count, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_count", dec_count, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h2000);
    tick();
    chk("bp_ready_a", in_ready, 1);
    drive(1'b1, 32'h00200113, 32'h2004);
    tick();
    chk("bp_ready_b", in_ready, 0);
    chk("bp_hold_a", out_instr, 32'h00100093);
    drive(1'b1, 32'h00300193, 32'h2008);
    tick();
    chk("bp_ready_c", in_ready, 0);
    chk("bp_stable_a", out_instr, 32'h00100093);
    chk("bp_stable_imm", out_imm, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_instr, 32'h00200113);
    chk("bp_ready_rel", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_out_c", out_instr, 32'h00300193);
    chk("bp_pc_c", out_pc, 32'h2008);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_count", dec_count, 3);
    out_ready = 1'b0;
    drive(1'b1, 32'h00500293, 32'h3000);
    tick();
    drive(1'b1, 32'h00600313, 32'h3004);
    tick();
    chk("fl_full", in_ready, 0);
    drive(1'b1, 32'h00700393, 32'h3008);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_count", dec_count, 3);
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_gone", out_valid, 0);
    chk("fl_gone_count", dec_count, 3);
    drive(1'b1, 32'h00000000, 32'h4000);
    for (int i = 0; i < 13; i++) tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("wrap_pre", dec_count, 15);
    chk("wrap_illegal", out_illegal, 1);
    tick();
    chk("wrap_zero", dec_count, 0);
    chk("wrap_empty", out_valid, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00800413, 32'h5000);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("mid_valid", out_valid, 1);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", dec_count, 0);
    chk("mid_rst_instr", out_instr, 0);
    chk("mid_rst_ready", in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width of pc and imm; legal values 32 or 64.
REQ-002 Parameter CNT_W, 32, width of the decoded-instruction counter.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream instruction valid.
REQ-006 Port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 Port in_instr  input  32  raw instruction word.
REQ-008 Port in_pc  input  XLEN  address of in_instr.
REQ-009 Port flush  input  1  discard all held instructions.
REQ-010 Port out_valid  output  1  decoded bundle valid.
REQ-011 Port out_ready  input  1  downstream accepts the bundle.
REQ-012 Ports out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5, out_funct7 7, all outputs, raw fields at bits [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
REQ-013 Port out_imm  output  XLEN  sign-extended immediate for the decoded format.
REQ-014 Port out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=6.
REQ-015 Port out_illegal  output  1  opcode not recognised.
REQ-016 Ports out_pc XLEN and out_instr 32, both outputs, pass-through of in_pc and in_instr.
REQ-017 Port dec_count  output  CNT_W  count of output handshakes.

Function
REQ-018 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-019 Latency is one cycle: an instruction accepted in cycle N is presented on out_* in cycle N+1 when the output register is empty or drains in N.
REQ-020 Storage is an output register plus one skid entry; in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-021 Input accepted while the output register holds an unaccepted bundle goes to the skid entry; on the next output transfer the skid entry moves to the output register.
REQ-022 Bundles emerge in acceptance order; no loss or duplication under any valid/ready pattern.
REQ-023 out_* fields stay stable while out_valid && !out_ready.
REQ-024 Format and immediate by opcode: 0110011 R, imm 0; 0010011/0000011/1100111/1110011 I, imm = sext(instr[31:20]); 0100011 S, imm = sext({[31:25],[11:7]}); 1100011 B, imm = sext({[31],[7],[30:25],[11:8],0}); 0110111/0010111 U, imm = sext({[31:12],12'b0}); 1101111 J, imm = sext({[31],[19:12],[20],[30:21],0}).
REQ-025 Any other opcode, or instr[1:0] != 2'b11, gives out_fmt NONE, out_imm 0, out_illegal 1; such bundles still flow and count.
REQ-026 Flush asserted in cycle N clears the output register and skid entry, so out_valid=0 and in_ready=1 in N+1; an input transfer in cycle N is discarded; flush beats simultaneous accept and output transfer.
REQ-027 dec_count increments by 1 per output transfer, wraps from all-ones to 0, and is unaffected by flush.

Reset
REQ-028 While reset is high at a clock edge: out_valid=0, skid empty, in_ready=1 in the following cycle, dec_count=0, all out_* data fields=0.
REQ-029 Reset mid-operation discards held bundles without emitting them; reset beats flush and handshakes.

Structure
REQ-030 Package decode_pkg holds the opcode constants, the fmt_e enum (REQ-014 encodings), and a dec_bundle_t struct of the decoded fields.
REQ-031 Immediate and format extraction is a combinational sub-module imm_gen, instanced once at the input side so both storage slots hold decoded bundles.

Verification
REQ-032 0xFFF00093 (addi x1,x0,-1), out_ready=1: next cycle out_fmt=I, out_rd=1, out_rs1=0, out_imm all-ones, out_illegal=0.
REQ-033 0x0020A423 (sw x2,8(x1)) gives out_fmt=S, out_imm=8, rs1=1, rs2=2; 0xFE000EE3 (beq) gives out_fmt=B, out_imm=-4; 0x123452B7 (lui x5) gives out_fmt=U, out_imm=0x12345000 sign-extended.
REQ-034 Three back-to-back inputs with out_ready=0 for 3 cycles: in_ready falls after 2 accepted, third held upstream; after release all 3 emerge in order, dec_count=3.
REQ-035 Flush with both slots full plus in_valid=1: next cycle out_valid=0, in_ready=1, dec_count unchanged, and the flushed instructions never appear.
REQ-036 0x00000000 gives out_illegal=1, out_fmt=NONE, out_imm=0; dec_count preset near all-ones wraps to 0 on the next output transfer.
